// File: rtl/multiword_subtractor.sv
// Multi-limb unsigned subtractor: one W-bit limb per cycle, LSB first.
// Ports: clk, rst (sync, active-high); first_term, second_term, borrow_in,
//   in_valid/in_ready (input handshake); difference, borrow_out,
//   out_valid/out_ready (output handshake).
// Optional: define MULTIWORD_SUBTRACTOR_FLAGS_EN to add zero/overflow outputs.
module multiword_subtractor #(
  parameter int N = 32,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] first_term,
  input  logic [N-1:0] second_term,
  input  logic         borrow_in,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] difference,
  output logic         borrow_out,
`ifdef MULTIWORD_SUBTRACTOR_FLAGS_EN
  output logic         zero,
  output logic         overflow,
`endif
  output logic         out_valid,
  input  logic         out_ready
);

  localparam int K  = N / W;
  localparam int IW = (K > 1) ? $clog2(K) : 1;
  localparam logic [IW-1:0] LAST = IW'(K - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [N-1:0]  a_q;
  logic [N-1:0]  b_q;
  logic [IW-1:0] idx;
  logic          brw;

  logic [W-1:0]  a_limb;
  logic [W-1:0]  b_limb;
  logic [W-1:0]  d_limb;
  logic          limb_brw;
  logic [N-1:0]  diff_nxt;
  logic          last;
  logic          in_hs;
  int            off;

  // Current limb: W+1-bit subtract so the top bit is the borrow out.
  always_comb begin
    off      = int'(idx) * W;
    a_limb   = a_q[off +: W];
    b_limb   = b_q[off +: W];
    {limb_brw, d_limb} = {1'b0, a_limb} - {1'b0, b_limb}
                       - {{W{1'b0}}, brw};
    diff_nxt = difference;
    diff_nxt[off +: W] = d_limb;
    last     = (idx == LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign in_hs = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q        <= '0;
      b_q        <= '0;
      brw        <= 1'b0;
      idx        <= '0;
      difference <= '0;
      borrow_out <= 1'b0;
`ifdef MULTIWORD_SUBTRACTOR_FLAGS_EN
      zero       <= 1'b0;
      overflow   <= 1'b0;
`endif
    end else if (in_hs) begin
      a_q <= first_term;
      b_q <= second_term;
      brw <= borrow_in;
      idx <= '0;
    end else if (state == RUN) begin
      difference <= diff_nxt;
      brw        <= limb_brw;
      idx        <= last ? '0 : idx + IW'(1);
      if (last) begin
        borrow_out <= limb_brw;
`ifdef MULTIWORD_SUBTRACTOR_FLAGS_EN
        zero       <= (diff_nxt == '0);
        // Signed overflow: operand signs differ and the result sign
        // disagrees with the minuend sign.
        overflow   <= (a_q[N-1] ^ b_q[N-1])
                    & (d_limb[W-1] ^ a_q[N-1]);
`endif
      end
    end
  end

endmodule
